// File: rtl/data_mem_mmio.sv
// Data RAM plus pong MMIO registers (tick timer, buttons, vsync/frame, LEDs).
// Reads are combinational from the address; writes commit on the rising clock edge.
module data_mem_mmio #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned TICK_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [3:0]  btn,
    input  logic        vsync,
    output logic [7:0]  led
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [29:0] W_TIMER = 30'h400;
    localparam logic [29:0] W_TICK  = 30'h401;
    localparam logic [29:0] W_BTN   = 30'h402;
    localparam logic [29:0] W_FRAME = 30'h403;
    localparam logic [29:0] W_LED   = 30'h404;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TIMER,
        SEL_TICK,
        SEL_BTN,
        SEL_FRAME,
        SEL_LED
    } sel_t;

    logic [31:0]   mem [RAM_WORDS];
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    sel_t          sel;

    logic [PW-1:0] presc;
    logic [31:0]   timer_cnt;
    logic          tick_flag;
    logic          wrap;

    logic [3:0]    btn_s1, btn_s2, btn_d, btn_flag, btn_rise;
    logic          vs_s1, vs_s2, vs_d, frame_flag, vs_rise;
    logic [15:0]   frame_cnt;

    logic          wr_timer, wr_tick, wr_btn, wr_frame, wr_led;
    logic          unused_addr_bits;

    assign word_addr        = ALUResult[31:2];
    assign ram_idx          = word_addr[AW-1:0];
    assign unused_addr_bits = ^ALUResult[1:0];

    always_comb begin
        sel = SEL_NONE;
        if (word_addr[29:AW] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                W_TIMER: sel = SEL_TIMER;
                W_TICK:  sel = SEL_TICK;
                W_BTN:   sel = SEL_BTN;
                W_FRAME: sel = SEL_FRAME;
                W_LED:   sel = SEL_LED;
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign wr_timer = MemWrite && (sel == SEL_TIMER);
    assign wr_tick  = MemWrite && (sel == SEL_TICK);
    assign wr_btn   = MemWrite && (sel == SEL_BTN);
    assign wr_frame = MemWrite && (sel == SEL_FRAME);
    assign wr_led   = MemWrite && (sel == SEL_LED);

    // RAM has no reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (MemWrite && (sel == SEL_RAM))
            mem[ram_idx] <= WriteData;
    end

    assign wrap = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            timer_cnt <= '0;
        end else if (wr_timer) begin
            presc     <= '0;
            timer_cnt <= '0;
        end else begin
            presc <= wrap ? '0 : presc + PW'(1);
            if (wrap)
                timer_cnt <= timer_cnt + 32'd1;
        end
    end

    assign btn_rise = btn_s2 & ~btn_d;
    assign vs_rise  = vs_s2 & ~vs_d;

    // Sticky flags: a same-cycle set overrides the write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_d      <= '0;
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_d       <= 1'b0;
            tick_flag  <= 1'b0;
            btn_flag   <= '0;
            frame_flag <= 1'b0;
            frame_cnt  <= '0;
            led        <= '0;
        end else begin
            btn_s1     <= btn;
            btn_s2     <= btn_s1;
            btn_d      <= btn_s2;
            vs_s1      <= vsync;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            tick_flag  <= (tick_flag & ~(wr_tick & WriteData[0])) | wrap;
            btn_flag   <= (btn_flag & ~({4{wr_btn}} & WriteData[7:4])) | btn_rise;
            frame_flag <= (frame_flag & ~(wr_frame & WriteData[0])) | vs_rise;
            if (vs_rise)
                frame_cnt <= frame_cnt + 16'd1;
            if (wr_led)
                led <= WriteData[7:0];
        end
    end

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:   ReadData = mem[ram_idx];
            SEL_TIMER: ReadData = timer_cnt;
            SEL_TICK:  ReadData = {31'b0, tick_flag};
            SEL_BTN:   ReadData = {24'b0, btn_flag, btn_s2};
            SEL_FRAME: ReadData = {frame_cnt, 15'b0, frame_flag};
            SEL_LED:   ReadData = {24'b0, led};
            default:   ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio with TICK_DIV=4; expected values queued then popped at compare.
module tb_data_mem_mmio;

    localparam logic [31:0] A_TIMER = 32'h1000;
    localparam logic [31:0] A_TICK  = 32'h1004;
    localparam logic [31:0] A_BTN   = 32'h1008;
    localparam logic [31:0] A_FRAME = 32'h100C;
    localparam logic [31:0] A_LED   = 32'h1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [3:0]  btn;
    logic        vsync;
    logic [7:0]  led;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    data_mem_mmio #(.RAM_WORDS(64), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .btn(btn), .vsync(vsync), .led(led)
    );

    always #5 clk = ~clk;

    task automatic rd(input logic [31:0] a);
        ALUResult = a;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({24'b0, led} !== exp) begin errors++; $display("FAIL reset_led got=%h want=%h", led, exp); end
        exp_q.push_back(32'h0); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL reset_timer got=%h want=%h", ReadData, exp); end
        repeat (5) @(negedge clk);
        exp_q.push_back(32'h0); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL reset_timer_held got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_TICK);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL reset_tick got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL reset_btn got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_FRAME);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL reset_frame got=%h want=%h", ReadData, exp); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ram;
        wr(32'h10, 32'hDEADBEEF);
        wr(32'h14, 32'h12345678);
        wr(32'h00, 32'hA5A50000);
        wr(32'hFC, 32'h0BADF00D);
        wr(32'h100, 32'hFFFFFFFF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hA5A50000);
        exp_q.push_back(32'h0BADF00D);
        exp_q.push_back(32'h0);
        rd(32'h10);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_10 got=%h want=%h", ReadData, exp); end
        rd(32'h14);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_14 got=%h want=%h", ReadData, exp); end
        rd(32'h13);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_13 got=%h want=%h", ReadData, exp); end
        rd(32'h17);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_17 got=%h want=%h", ReadData, exp); end
        rd(32'h00);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_00_no_alias got=%h want=%h", ReadData, exp); end
        rd(32'hFC);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_last got=%h want=%h", ReadData, exp); end
        rd(32'h100);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL ram_beyond got=%h want=%h", ReadData, exp); end
    endtask

    task automatic test_timer;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        exp_q.push_back(32'd3); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL timer_12clk got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'd1); rd(A_TICK);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL tick_set got=%h want=%h", ReadData, exp); end
        wr(A_TICK, 32'h1);
        exp_q.push_back(32'd0); rd(A_TICK);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL tick_w1c got=%h want=%h", ReadData, exp); end
        repeat (2) @(negedge clk);
        wr(A_TIMER, 32'h1234);   // lands on the wrap edge
        exp_q.push_back(32'd0); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL timer_clear_on_wrap got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'd1); rd(A_TICK);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL tick_on_clear_wrap got=%h want=%h", ReadData, exp); end
        @(negedge clk);
        wr(A_TIMER, 32'h0);
        repeat (3) @(negedge clk);
        exp_q.push_back(32'd0); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL presc_cleared got=%h want=%h", ReadData, exp); end
        @(negedge clk);
        exp_q.push_back(32'd1); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL timer_after_clear got=%h want=%h", ReadData, exp); end
    endtask

    task automatic test_buttons;
        btn = 4'b0100;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h04); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_level_2clk got=%h want=%h", ReadData, exp); end
        @(negedge clk);
        exp_q.push_back(32'h44); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_flag_3clk got=%h want=%h", ReadData, exp); end
        wr(A_BTN, 32'h40);
        exp_q.push_back(32'h04); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_w1c_held got=%h want=%h", ReadData, exp); end
        btn = 4'b0000;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h00); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_released got=%h want=%h", ReadData, exp); end
        btn = 4'b0100;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h44); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_repress got=%h want=%h", ReadData, exp); end
        wr(A_BTN, 32'h8F);
        exp_q.push_back(32'h44); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL btn_w1c_zero got=%h want=%h", ReadData, exp); end
    endtask

    task automatic test_vsync;
        for (int i = 0; i < 3; i++) begin
            vsync = 1'b1;
            repeat (3) @(negedge clk);
            vsync = 1'b0;
            repeat (3) @(negedge clk);
        end
        exp_q.push_back(32'h0003_0001); rd(A_FRAME);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL frame_3_edges got=%h want=%h", ReadData, exp); end
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        wr(A_FRAME, 32'h1);      // commits on the same edge the flag sets
        exp_q.push_back(32'h0004_0001); rd(A_FRAME);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL frame_set_wins got=%h want=%h", ReadData, exp); end
        wr(A_FRAME, 32'h1);
        exp_q.push_back(32'h0004_0000); rd(A_FRAME);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL frame_w1c got=%h want=%h", ReadData, exp); end
        vsync = 1'b0;
    endtask

    task automatic test_led;
        wr(A_LED, 32'h1A5);
        exp_q.push_back(32'hA5);
        exp = exp_q.pop_front(); checks++;
        if ({24'b0, led} !== exp) begin errors++; $display("FAIL led_port got=%h want=%h", led, exp); end
        exp_q.push_back(32'hA5); rd(A_LED);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL led_read got=%h want=%h", ReadData, exp); end
        wr(32'h2000, 32'hFFFFFFFF);
        exp_q.push_back(32'h0); rd(32'h2000);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL unmapped_read got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'hA5);
        exp = exp_q.pop_front(); checks++;
        if ({24'b0, led} !== exp) begin errors++; $display("FAIL led_after_unmapped got=%h want=%h", led, exp); end
        exp_q.push_back(32'h0); rd(32'h1014);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL unmapped_1014 got=%h want=%h", ReadData, exp); end
    endtask

    task automatic test_reset_mid;
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({24'b0, led} !== exp) begin errors++; $display("FAIL midreset_led got=%h want=%h", led, exp); end
        exp_q.push_back(32'h0); rd(A_TIMER);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL midreset_timer got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_TICK);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL midreset_tick got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_BTN);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL midreset_btn got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'h0); rd(A_FRAME);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL midreset_frame got=%h want=%h", ReadData, exp); end
        exp_q.push_back(32'hDEADBEEF); rd(32'h10);
        exp = exp_q.pop_front(); checks++;
        if (ReadData !== exp) begin errors++; $display("FAIL midreset_ram got=%h want=%h", ReadData, exp); end
        @(negedge clk);
        reset = 1'b0;
        btn   = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        btn       = '0;
        vsync     = 1'b0;
        test_reset;
        test_ram;
        test_timer;
        test_buttons;
        test_vsync;
        test_led;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
